// File: rtl/cp0_ctrl_pkg.sv
// Shared CP0 definitions: bus widths, register addresses, field positions,
// exception type encodings and the exception-type to ExcCode mapping.
package cp0_ctrl_pkg;

    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 32;
    localparam int CP0_ADDR_W = 5;
    localparam int EXC_TYPE_W = 4;

    localparam logic [CP0_ADDR_W-1:0] CP0_REG_BADVADDR = 5'd8;
    localparam logic [CP0_ADDR_W-1:0] CP0_REG_COUNT    = 5'd9;
    localparam logic [CP0_ADDR_W-1:0] CP0_REG_COMPARE  = 5'd11;
    localparam logic [CP0_ADDR_W-1:0] CP0_REG_STATUS   = 5'd12;
    localparam logic [CP0_ADDR_W-1:0] CP0_REG_CAUSE    = 5'd13;
    localparam logic [CP0_ADDR_W-1:0] CP0_REG_EPC      = 5'd14;
    localparam logic [CP0_ADDR_W-1:0] CP0_REG_CONFIG0  = 5'd16;
    // No select field on the MTC0 path, so Config1 gets its own address
    localparam logic [CP0_ADDR_W-1:0] CP0_REG_CONFIG1  = 5'd17;

    localparam logic [DATA_W-1:0] CP0_REG_STATUS_VALUE  = 32'h1000_0000;
    localparam logic [DATA_W-1:0] CP0_REG_CONFIG0_VALUE = 32'h8000_0003;
    localparam logic [DATA_W-1:0] CP0_REG_CONFIG1_VALUE = 32'h0000_0000;

    localparam int CP0_SEG_BD      = 31;
    localparam int CP0_SEG_TI      = 30;
    localparam int CP0_SEG_IP      = 8;
    localparam int CP0_SEG_EXCCODE = 2;
    localparam int CP0_SEG_BEV     = 22;
    localparam int CP0_SEG_IM      = 8;
    localparam int CP0_SEG_EXL     = 1;
    localparam int CP0_SEG_IE      = 0;

    localparam logic [DATA_W-1:0] CP0_STATUS_WMASK = 32'h0040_FF03;

    typedef enum logic [EXC_TYPE_W-1:0] {
        EXC_TYPE_NONE = 4'd0,
        EXC_TYPE_INT  = 4'd1,
        EXC_TYPE_IF   = 4'd2,
        EXC_TYPE_ADEL = 4'd3,
        EXC_TYPE_RI   = 4'd4,
        EXC_TYPE_OV   = 4'd5,
        EXC_TYPE_BP   = 4'd6,
        EXC_TYPE_SYS  = 4'd7,
        EXC_TYPE_ADES = 4'd8,
        EXC_TYPE_ERET = 4'd9
    } exc_type_e;

    localparam logic [4:0] CP0_EXCCODE_INT  = 5'd0;
    localparam logic [4:0] CP0_EXCCODE_ADEL = 5'd4;
    localparam logic [4:0] CP0_EXCCODE_ADES = 5'd5;
    localparam logic [4:0] CP0_EXCCODE_SYS  = 5'd8;
    localparam logic [4:0] CP0_EXCCODE_BP   = 5'd9;
    localparam logic [4:0] CP0_EXCCODE_RI   = 5'd10;
    localparam logic [4:0] CP0_EXCCODE_OV   = 5'd12;

    function automatic logic exc_is_trap(input logic [EXC_TYPE_W-1:0] t);
        return (t == EXC_TYPE_INT)  || (t == EXC_TYPE_IF) || (t == EXC_TYPE_ADEL) ||
               (t == EXC_TYPE_RI)   || (t == EXC_TYPE_OV) || (t == EXC_TYPE_BP)   ||
               (t == EXC_TYPE_SYS)  || (t == EXC_TYPE_ADES);
    endfunction

    function automatic logic [4:0] exc_code(input logic [EXC_TYPE_W-1:0] t);
        case (t)
            EXC_TYPE_IF, EXC_TYPE_ADEL: return CP0_EXCCODE_ADEL;
            EXC_TYPE_ADES:              return CP0_EXCCODE_ADES;
            EXC_TYPE_RI:                return CP0_EXCCODE_RI;
            EXC_TYPE_OV:                return CP0_EXCCODE_OV;
            EXC_TYPE_BP:                return CP0_EXCCODE_BP;
            EXC_TYPE_SYS:               return CP0_EXCCODE_SYS;
            default:                    return CP0_EXCCODE_INT;
        endcase
    endfunction

endpackage

// File: rtl/cp0_int_sync.sv
// Single-line level synchroniser, STAGES flops deep, cleared by synchronous reset.
module cp0_int_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (!rst) begin
            chain <= '0;
        end else begin
            chain[0] <= async_in;
            for (int s = 1; s < STAGES; s++) begin
                chain[s] <= chain[s-1];
            end
        end
    end

    assign sync_out = chain[STAGES-1];

endmodule

// File: rtl/cp0_ctrl.sv
// Second-generation CP0: prescaled Count/Compare timer, synchronised hardware
// interrupts and registered int_req_o. Define CP0_TIMER_INT_EN to build the Compare/TI timer.
module cp0_ctrl
    import cp0_ctrl_pkg::*;
#(
    parameter int HW_INT_NUM      = 6,
    parameter int COUNT_DIV       = 2,
    parameter int INT_SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cp0_write_en,
    input  logic [CP0_ADDR_W-1:0] cp0_write_addr,
    input  logic [DATA_W-1:0]     cp0_write_data,
    input  logic [CP0_ADDR_W-1:0] cp0_read_addr,
    input  logic [HW_INT_NUM-1:0] interrupt_i,
    input  logic [EXC_TYPE_W-1:0] exception_type,
    input  logic                  delayslot_flag,
    input  logic [ADDR_W-1:0]     current_pc_addr,
    input  logic [ADDR_W-1:0]     cp0_badvaddr_write_data,
    output logic [DATA_W-1:0]     data_o,
    output logic [DATA_W-1:0]     count_o,
    output logic [DATA_W-1:0]     status_o,
    output logic [DATA_W-1:0]     cause_o,
    output logic [DATA_W-1:0]     epc_o,
    output logic [DATA_W-1:0]     config0_o,
    output logic                  timer_int_o,
    output logic                  int_req_o
);

`ifdef CP0_TIMER_INT_EN
    localparam bit TIMER_EN = 1'b1;
`else
    localparam bit TIMER_EN = 1'b0;
`endif

    localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

    logic [PW-1:0]     presc_q, presc_d;
    logic [DATA_W-1:0] badvaddr_q, badvaddr_d;
    logic [DATA_W-1:0] count_q, count_d;
    logic [DATA_W-1:0] compare_q, compare_d;
    logic [DATA_W-1:0] status_q, status_d;
    logic [DATA_W-1:0] epc_q, epc_d;
    logic [DATA_W-1:0] config0_q, config0_d;
    logic              bd_q, bd_d;
    logic              ti_q, ti_d;
    logic [4:0]        exccode_q, exccode_d;
    logic [1:0]        ip_sw_q, ip_sw_d;
    logic [5:0]        ip_hw_q;
    logic              int_req_q, int_req_d;

    logic [HW_INT_NUM-1:0] int_sync;
    logic [5:0]            hw_lines;
    logic [7:0]            ip;
    logic                  presc_wrap;
    logic                  exc_trap;
    logic                  exc_eret;
    logic                  exc_badv;

    for (genvar i = 0; i < HW_INT_NUM; i++) begin : g_sync
        cp0_int_sync #(.STAGES(INT_SYNC_STAGES)) u_sync (
            .clk      (clk),
            .rst      (rst),
            .async_in (interrupt_i[i]),
            .sync_out (int_sync[i])
        );
    end

    always_comb begin
        hw_lines = '0;
        hw_lines[HW_INT_NUM-1:0] = int_sync;
    end

    // TI joins IP[7] combinationally so int_req_o follows TI by one edge
    assign ip         = {ti_q | ip_hw_q[5], ip_hw_q[4:0], ip_sw_q};
    assign presc_wrap = (presc_q == PW'(COUNT_DIV - 1));
    assign exc_trap   = exc_is_trap(exception_type);
    assign exc_eret   = (exception_type == EXC_TYPE_ERET);
    assign exc_badv   = (exception_type == EXC_TYPE_IF) || (exception_type == EXC_TYPE_ADEL) ||
                        (exception_type == EXC_TYPE_ADES);

    always_comb begin
        presc_d    = presc_q;
        badvaddr_d = badvaddr_q;
        count_d    = count_q;
        compare_d  = compare_q;
        status_d   = status_q;
        epc_d      = epc_q;
        config0_d  = config0_q;
        bd_d       = bd_q;
        ti_d       = ti_q;
        exccode_d  = exccode_q;
        ip_sw_d    = ip_sw_q;

        if (cp0_write_en && cp0_write_addr == CP0_REG_COUNT) begin
            count_d = cp0_write_data;
            presc_d = '0;
        end else if (presc_wrap) begin
            presc_d = '0;
            count_d = count_q + 32'd1;
            if (TIMER_EN && count_d == compare_q) ti_d = 1'b1;
        end else begin
            presc_d = presc_q + PW'(1);
        end

        if (cp0_write_en) begin
            case (cp0_write_addr)
                CP0_REG_STATUS:  status_d = (status_q & ~CP0_STATUS_WMASK) |
                                            (cp0_write_data & CP0_STATUS_WMASK);
                CP0_REG_CAUSE:   ip_sw_d = cp0_write_data[9:8];
                CP0_REG_EPC:     epc_d = cp0_write_data;
                CP0_REG_CONFIG0: config0_d[2:0] = cp0_write_data[2:0];
                CP0_REG_COMPARE: begin
                    if (TIMER_EN) begin
                        compare_d = cp0_write_data;
                        ti_d      = 1'b0;
                    end
                end
                default: ;
            endcase
        end

        // Exception state is applied after MTC0 so it wins on shared fields
        if (exc_trap) begin
            exccode_d               = exc_code(exception_type);
            status_d[CP0_SEG_EXL]   = 1'b1;
            if (!status_q[CP0_SEG_EXL]) begin
                epc_d = delayslot_flag ? current_pc_addr - 32'd4 : current_pc_addr;
                bd_d  = delayslot_flag;
            end
            if (exc_badv) badvaddr_d = cp0_badvaddr_write_data;
        end else if (exc_eret) begin
            status_d[CP0_SEG_EXL] = 1'b0;
        end

        int_req_d = status_q[CP0_SEG_IE] & ~status_q[CP0_SEG_EXL] &
                    (|(ip & status_q[CP0_SEG_IM +: 8]));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            presc_q    <= '0;
            badvaddr_q <= '0;
            count_q    <= '0;
            compare_q  <= '0;
            status_q   <= CP0_REG_STATUS_VALUE;
            epc_q      <= '0;
            config0_q  <= CP0_REG_CONFIG0_VALUE;
            bd_q       <= 1'b0;
            ti_q       <= 1'b0;
            exccode_q  <= '0;
            ip_sw_q    <= '0;
            ip_hw_q    <= '0;
            int_req_q  <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            badvaddr_q <= badvaddr_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            status_q   <= status_d;
            epc_q      <= epc_d;
            config0_q  <= config0_d;
            bd_q       <= bd_d;
            ti_q       <= ti_d;
            exccode_q  <= exccode_d;
            ip_sw_q    <= ip_sw_d;
            ip_hw_q    <= hw_lines;
            int_req_q  <= int_req_d;
        end
    end

    assign cause_o     = {bd_q, ti_q, 14'd0, ip, 1'b0, exccode_q, 2'b00};
    assign count_o     = count_q;
    assign status_o    = status_q;
    assign epc_o       = epc_q;
    assign config0_o   = config0_q;
    assign timer_int_o = ti_q;
    assign int_req_o   = int_req_q;

    always_comb begin
        data_o = '0;
        if (rst) begin
            case (cp0_read_addr)
                CP0_REG_BADVADDR: data_o = badvaddr_q;
                CP0_REG_COUNT:    data_o = count_q;
                CP0_REG_COMPARE:  data_o = compare_q;
                CP0_REG_STATUS:   data_o = status_q;
                CP0_REG_CAUSE:    data_o = cause_o;
                CP0_REG_EPC:      data_o = epc_q;
                CP0_REG_CONFIG0:  data_o = config0_q;
                CP0_REG_CONFIG1:  data_o = CP0_REG_CONFIG1_VALUE;
                default:          data_o = '0;
            endcase
        end
    end

endmodule

// File: doc/cp0_ctrl.md
# cp0_ctrl

Parametrised second-generation System Control Coprocessor (CP0) for the MIPS core. It sits beside the register file and is read and written by MTC0/MFC0 from the writeback stage, and it latches exception state from the commit point. It adds three things to the first-generation CP0:
- a prescaled Count/Compare timer interrupt;
- synchronised, width-configurable hardware interrupt lines;
- a registered interrupt-request output with MIPS32 EXL-nesting rules.

## Interface
Parameters:
- HW_INT_NUM, 6, number of external interrupt lines (1..6); line i maps to Cause.IP[i+2]
- COUNT_DIV, 2, clock cycles per Count increment (power of two, ≥1)
- INT_SYNC_STAGES, 2, flip-flop stages on each external interrupt line (≥1)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- cp0_write_en  in  1  MTC0 write strobe
- cp0_write_addr  in  `CP0_ADDR_BUS`  write register select
- cp0_write_data  in  `DATA_BUS`  write data
- cp0_read_addr  in  `CP0_ADDR_BUS`  MFC0 read select
- interrupt_i  in  HW_INT_NUM  asynchronous level interrupts
- exception_type  in  `EXC_TYPE_BUS`  committed exception code; none = default code
- delayslot_flag  in  1  excepting instruction is in a delay slot
- current_pc_addr  in  `ADDR_BUS`  PC of the excepting instruction
- cp0_badvaddr_write_data  in  `ADDR_BUS`  faulting address
- data_o  out  `DATA_BUS`  combinational read data
- count_o, status_o, cause_o, epc_o, config0_o  out  `DATA_BUS`  live register values
- timer_int_o  out  1  Cause.TI
- int_req_o  out  1  registered interrupt request to the pipeline

## Operation
- Reset (rst=0 at posedge):
  - Status = `CP0_REG_STATUS_VALUE`; Config0 = `CP0_REG_CONFIG0_VALUE`.
  - BadVAddr, Count, Compare, Cause, EPC, Config1, the prescaler and all sync flops = 0.
  - int_req_o = 0; data_o = 0 while rst=0.
- Count:
  - The prescaler counts 0..COUNT_DIV-1. Count increments when the prescaler wraps.
  - Count wraps 0xFFFFFFFF→0.
  - An MTC0 to Count loads the data and clears the prescaler.
- Timer:
  - Cause.TI (bit 30) sets on the Count increment that makes Count == Compare. This applies even when Compare = 0.
  - TI is sticky. An MTC0 to Compare loads Compare and clears TI.
- Interrupt lines:
  - IP[7] = TI | (HW_INT_NUM==6 ? sync[5] : 0).
  - IP[HW_INT_NUM+1:2] = synchronised interrupt_i. Unused IP bits read 0.
  - IP[1:0] are software-written via Cause.
- Writable fields:
  - Status[22], Status[15:8], Status[1:0].
  - Cause[9:8].
  - EPC (full register).
  - Compare (full register).
  - Config0[2:0].
  - Writes to other addresses or to read-only fields are ignored.
- Exception entry (INT, IF/ADEL, RI, OV, BP, SYS, ADES):
  - Sets ExcCode, using the same mapping as generation 1.
  - Sets Status.EXL = 1.
  - BadVAddr is loaded only for IF/ADEL/ADES.
  - EPC and Cause.BD update only if EXL was 0 before the exception. EPC = delayslot_flag ? pc-4 : pc.
- ERET clears EXL.
- Priority: if an exception and an MTC0 target the same field in one cycle, the exception wins. Non-overlapping fields both update.
- int_req_o is registered: next = Status.IE & ~Status.EXL & |(Cause.IP[7:0] & Status.IM[7:0]).

## Timing
- External line → Cause.IP: INT_SYNC_STAGES+1 cycles.
- Cause.IP → int_req_o: +1 cycle.
- Count == Compare reached at edge N → TI visible at edge N. TI → int_req_o at edge N+1.
- MTC0 takes effect at the next edge. MFC0 reads current register state combinationally, so there is no write→read bypass.
- An exception arriving while int_req_o=1 clears int_req_o one cycle after EXL sets.
- rst mid-operation aborts everything. TI and pending IP are lost.

## Configuration
- CP0_TIMER_INT_EN defined: Compare register, TI and the IP[7] timer source are present.
- CP0_TIMER_INT_EN undefined: Compare reads 0 and writes to it are ignored. TI and timer_int_o are tied to 0. Count still runs.

## Structure
- Add to the shared cp0 include:
  - `CP0_SEG_TI`, `CP0_SEG_IP`, `CP0_SEG_IM`, `CP0_SEG_IE`
  - `CP0_REG_CONFIG1`
- Reuse the existing `CP0_SEG_*`, `CP0_EXCCODE_*` and `EXC_TYPE_*` definitions.
- One sub-module: cp0_int_sync. It is a per-line INT_SYNC_STAGES-deep synchroniser, instantiated HW_INT_NUM wide.

## Test plan
- Reset, then read every address → values match the reset list; int_req_o=0. Assert rst mid-count → Count=0 on the next edge.
- COUNT_DIV=2, Compare=5, Status=0x0000_8001 → TI=1 and timer_int_o=1 when Count reaches 5; int_req_o=1 one cycle later; MTC0 Compare=9 → TI=0.
- interrupt_i[0] raised, Status IM2=1 and IE=1 → Cause[10]=1 after 3 cycles and int_req_o=1 after 4 cycles.
- SYS at pc 0xBFC0_0100 with delayslot=1 → EPC=0xBFC0_00FC, BD=1, EXL=1. A second ADEL while EXL=1 → EPC unchanged, ExcCode=4, BadVAddr updated.
- MTC0 Status (EXL=0) in the same cycle as OV → EXL=1; IM from the write is retained.
- Build without CP0_TIMER_INT_EN: MTC0 Compare=0, run 10 cycles → TI stays 0 and Compare reads 0.
